// File: rtl/alu_arb_pkg.sv
// Shared constants for the accumulator-ALU request arbiter: datapath widths and ALU opcodes.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'd0;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'd1;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'd2;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'd3;
    localparam logic [SEL_W-1:0] OP_ADDA = 4'd4;
    localparam logic [SEL_W-1:0] OP_MULA = 4'd5;
    localparam logic [SEL_W-1:0] OP_MAC  = 4'd6;
    localparam logic [SEL_W-1:0] OP_AND  = 4'd7;
    localparam logic [SEL_W-1:0] OP_OR   = 4'd8;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'd9;
    localparam logic [SEL_W-1:0] OP_NAND = 4'd10;
    localparam logic [SEL_W-1:0] OP_NOR  = 4'd11;
    localparam logic [SEL_W-1:0] OP_SHL  = 4'd12;
    localparam logic [SEL_W-1:0] OP_SHR  = 4'd13;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'd14;
    localparam logic [SEL_W-1:0] OP_LTH  = 4'd15;

    // Acc + 0: issued on idle cycles so the accumulator is left untouched.
    localparam logic [SEL_W-1:0] OP_HOLD = OP_ADDA;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first eligible requester after ptr, searching cyclically.
module alu_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [NUM_REQ-1:0] elig;

    assign elig = valid & mask;

    // Walk from the farthest slot to the nearest; the last hit is the closest after ptr.
    always_comb begin
        int c;
        logic [ID_W-1:0] ci;
        grant = '0;
        idx   = '0;
        c     = 0;
        ci    = '0;
        for (int d = NUM_REQ; d >= 1; d--) begin
            c  = (int'(ptr) + d) % NUM_REQ;
            ci = ID_W'(c);
            if (elig[ci]) begin
                grant     = '0;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one accumulator ALU with tagged results and owner grant locking.
// Optional ALU_ARB_LOCK_TIMEOUT_EN adds an idle timeout on held locks and a lock_err pulse.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ID_W     = 1,
    parameter int ALU_LAT  = 2,
    parameter int LOCK_TMO = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    input  logic [NUM_REQ-1:0]        req_lock,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_sel,
    input  logic [DATA_W-1:0]         alu_out,
    output logic                      lock_active,
    output logic [ID_W-1:0]           lock_owner
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    ,
    output logic                      lock_err
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("NUM_REQ must be in 2..8");
    end
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("ID_W must equal clog2(NUM_REQ)");
    end
    if (ALU_LAT < 1 || LOCK_TMO < 1) begin : g_bad_lat
        $error("ALU_LAT and LOCK_TMO must be at least 1");
    end

    logic [NUM_REQ-1:0][DATA_W-1:0] a_v, b_v;
    logic [NUM_REQ-1:0][SEL_W-1:0]  sel_v;
    logic [NUM_REQ-1:0]             mask, grant;
    logic [ID_W-1:0]                gidx, rr_ptr;
    logic                           hs;
    logic [ALU_LAT:1]               vld_pipe;
    logic [ID_W-1:0]                tag_pipe [1:ALU_LAT];

    assign a_v   = req_a;
    assign b_v   = req_b;
    assign sel_v = req_sel;

    always_comb begin
        mask = '1;
        if (lock_active) begin
            mask             = '0;
            mask[lock_owner] = 1'b1;
        end
    end

    alu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .mask  (mask),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    // Issue registers, result-latency pipeline and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= OP_HOLD;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            vld_pipe  <= '0;
            for (int i = 1; i <= ALU_LAT; i++) tag_pipe[i] <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            if (hs) begin
                alu_a   <= a_v[gidx];
                alu_b   <= b_v[gidx];
                alu_sel <= sel_v[gidx];
                rr_ptr  <= gidx;
            end else begin
                alu_a   <= '0;
                alu_b   <= '0;
                alu_sel <= OP_HOLD;
            end
            vld_pipe[1] <= hs;
            tag_pipe[1] <= gidx;
            for (int i = 2; i <= ALU_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
            rsp_valid <= vld_pipe[ALU_LAT];
            if (vld_pipe[ALU_LAT]) begin
                rsp_id   <= tag_pipe[ALU_LAT];
                rsp_data <= alu_out;
            end
        end
    end

`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_TMO + 1);
    logic [CNT_W-1:0] idle_cnt;
`endif

    // While locked only the owner can handshake, so any handshake restarts the idle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
            idle_cnt    <= '0;
            lock_err    <= 1'b0;
`endif
        end else begin
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
            lock_err <= 1'b0;
            if (hs) begin
                idle_cnt <= '0;
            end else if (lock_active) begin
                if (idle_cnt == CNT_W'(LOCK_TMO - 1)) begin
                    lock_active <= 1'b0;
                    lock_err    <= 1'b1;
                    idle_cnt    <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
`endif
            if (hs) begin
                if (req_lock[gidx]) begin
                    lock_active <= 1'b1;
                    lock_owner  <= gidx;
                end else begin
                    lock_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Random and directed checks of alu_req_arbiter against a transaction-level arbitration/ALU model.
module tb_alu_req_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int ALU_LAT = 2;
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    localparam int LOCK_TMO = 4;
`else
    localparam int LOCK_TMO = 16;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][7:0]   req_a = '0;
    logic [NUM_REQ-1:0][7:0]   req_b = '0;
    logic [NUM_REQ-1:0][3:0]   req_sel = '0;
    logic [NUM_REQ-1:0]        req_lock = '0;
    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [7:0]                rsp_data;
    logic [7:0]                alu_a, alu_b;
    logic [3:0]                alu_sel;
    logic [7:0]                alu_out = 8'd0;
    logic                      lock_active;
    logic [ID_W-1:0]           lock_owner;
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
    logic                      lock_err;
`endif

    alu_req_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LAT(ALU_LAT), .LOCK_TMO(LOCK_TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .req_lock(req_lock),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .lock_active(lock_active), .lock_owner(lock_owner)
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
        , .lock_err(lock_err)
`endif
    );

    always #5 clk = ~clk;

    // Accumulator ALU: Acc takes every result, one registered stage.
    function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] acc);
        logic [7:0] r;
        case (s)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a * b;
            4'd3:  r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4:  r = acc + a;
            4'd5:  r = acc * a;
            4'd6:  r = acc + a * b;
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: r = ~(a & b);
            4'd11: r = ~(a | b);
            4'd12: r = a << 1;
            4'd13: r = a >> 1;
            4'd14: r = (a == b) ? 8'd1 : 8'd0;
            default: r = (a < b) ? 8'd1 : 8'd0;
        endcase
        return r;
    endfunction

    logic [7:0] acc_env = 8'd0;
    always @(posedge clk) begin
        acc_env <= alu_fn(alu_sel, alu_a, alu_b, acc_env);
        alu_out <= alu_fn(alu_sel, alu_a, alu_b, acc_env);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: transactions, not registers.
    typedef struct { bit v; int id; logic [7:0] d; } ent_t;
    ent_t       pq[$];
    int         ptr, own, idle;
    bit         lk, exp_err;
    logic [7:0] acc_ref;
    logic [7:0] last_rsp;
    int         last_id, n_err_seen;

    function automatic logic [NUM_REQ-1:0] ref_grant(input logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] g;
        int c;
        g = '0;
        if (lk) begin
            if (v[own]) g[own] = 1'b1;
            return g;
        end
        for (int d = 1; d <= NUM_REQ; d++) begin
            c = (ptr + d) % NUM_REQ;
            if (v[c]) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic model_reset();
        ptr = NUM_REQ - 1;
        lk = 0; own = 0; idle = 0; exp_err = 0;
        pq.delete();
        for (int i = 0; i < ALU_LAT; i++) pq.push_back('{1'b0, 0, 8'd0});
        acc_ref = acc_env;
    endtask

    // One clock: check ready, advance the model across the edge, then check outputs.
    task automatic cycle();
        logic [NUM_REQ-1:0] er;
        int g;
        logic [7:0] d, ea, eb;
        logic [3:0] es;
        ent_t e;
        #1;
        er = ref_grant(req_valid);
        chk("req_ready", 32'(req_ready), 32'(er));
        g = -1;
        for (int i = 0; i < NUM_REQ; i++) if (er[i]) g = i;
        @(posedge clk);
        #1;
        exp_err = 0;
        if (g >= 0) begin
            d = alu_fn(req_sel[g], req_a[g], req_b[g], acc_ref);
            acc_ref = d;
            pq.push_back('{1'b1, g, d});
            ptr = g;
            idle = 0;
            if (req_lock[g]) begin lk = 1; own = g; end
            else lk = 0;
            ea = req_a[g]; eb = req_b[g]; es = req_sel[g];
        end else begin
            pq.push_back('{1'b0, 0, 8'd0});
            ea = 8'd0; eb = 8'd0; es = 4'd4;
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
            if (lk) begin
                idle++;
                if (idle == LOCK_TMO) begin lk = 0; idle = 0; exp_err = 1; end
            end
`endif
        end
        e = pq.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
        if (e.v) begin
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.d));
        end
        chk("alu_a", 32'(alu_a), 32'(ea));
        chk("alu_b", 32'(alu_b), 32'(eb));
        chk("alu_sel", 32'(alu_sel), 32'(es));
        chk("lock_active", 32'(lock_active), 32'(lk));
        if (lk) chk("lock_owner", 32'(lock_owner), 32'(own));
`ifdef ALU_ARB_LOCK_TIMEOUT_EN
        chk("lock_err", 32'(lock_err), 32'(exp_err));
        if (lock_err) n_err_seen++;
`endif
        if (rsp_valid) begin last_rsp = rsp_data; last_id = int'(rsp_id); end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_lock = '0;
        #1;
        chk("rst_alu_sel", 32'(alu_sel), 32'd4);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_lock_active", 32'(lock_active), 32'd0);
        chk("rst_lock_owner", 32'(lock_owner), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_op(input int r, input logic [3:0] s, input logic [7:0] a,
                          input logic [7:0] b, input bit l);
        req_sel[r] = s; req_a[r] = a; req_b[r] = b; req_lock[r] = l;
    endtask

    task automatic rand_ops();
        for (int r = 0; r < NUM_REQ; r++)
            set_op(r, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                   ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        last_rsp = 8'd0; last_id = 0; n_err_seen = 0;
        model_reset();
        #2;
        do_reset();

        // Single op: ADD 3+4 from requester 0.
        set_op(0, 4'd0, 8'd3, 8'd4, 1'b0);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        repeat (2) cycle();
        chk("single_data", 32'(last_rsp), 32'd7);
        chk("single_id", 32'(last_id), 32'd0);

        // Fairness: both requesters valid back to back.
        req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            set_op(0, 4'd0, 8'(i), 8'd1, 1'b0);
            set_op(1, 4'd1, 8'd100, 8'(i), 1'b0);
            cycle();
        end
        req_valid = 2'b00;
        repeat (2) cycle();

        // Locked MAC chain from requester 1 with requester 0 waiting.
        set_op(1, 4'd0, 8'd2, 8'd3, 1'b1);
        set_op(0, 4'd7, 8'hf0, 8'h3c, 1'b0);
        req_valid = 2'b10;
        cycle();
        req_valid = 2'b01;
        repeat (2) cycle();
        chk("lock_add_data", 32'(last_rsp), 32'd5);
        chk("lock_held", 32'(lock_active), 32'd1);
        cycle();
        set_op(1, 4'd6, 8'd4, 8'd5, 1'b0);
        req_valid = 2'b11;
        cycle();
        req_valid = 2'b00;
        repeat (2) cycle();
        chk("mac_data", 32'(last_rsp), 32'd25);
        chk("mac_id", 32'(last_id), 32'd1);

        // Hold ops across idle cycles, then ADDA 1 sees the kept accumulator.
        repeat (4) cycle();
        set_op(0, 4'd4, 8'd1, 8'd0, 1'b0);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        repeat (2) cycle();
        chk("hold_adda", 32'(last_rsp), 32'd26);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            req_valid = NUM_REQ'($urandom);
            rand_ops();
            cycle();
        end

        // Reset one cycle after a locked issue: its result must never appear.
        req_valid = 2'b00;
        repeat (3) cycle();
        set_op(0, 4'd0, 8'd9, 8'd9, 1'b1);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle();
        do_reset();
        repeat (4) cycle();

`ifdef ALU_ARB_LOCK_TIMEOUT_EN
        // Owner goes idle while holding the lock; timeout frees requester 1.
        n_err_seen = 0;
        set_op(0, 4'd0, 8'd1, 8'd1, 1'b1);
        set_op(1, 4'd0, 8'd2, 8'd2, 1'b0);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b10;
        repeat (6) cycle();
        chk("tmo_err_pulses", 32'(n_err_seen), 32'd1);
        req_valid = 2'b00;
        repeat (2) cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
